pipe_addsub: RTL and testbench

Parametrised, pipelined add/subtract/increment unit. It supersedes the fixed 8/16-bit ripple adders and incrementers in the sample-averaging and address-generation datapaths. The carry chain is split into equal segments with one register stage per segment, so wide operands close timing at the ADC sample clock. It adds selectable operation mode, optional saturation, signed-overflow reporting and a valid/ready handshake with backpressure.

---
 rtl/pipe_addsub_if.sv | 26 ++
 rtl/pipe_addsub.sv | 142 ++++++++++++++
 tb/tb_pipe_addsub.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
interface pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, q, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, q, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Segmented-carry add/sub/inc unit: one register stage per carry segment,
// optional wrap/unsigned/signed saturation and valid/ready backpressure.
module pipe_addsub #(
  parameter int WIDTH    = 16,
  parameter int SEGMENTS = 4,
  parameter int SAT      = 0
) (
  input logic         clk,
  input logic         rst_n,
  pipe_addsub_if.slave bus
);
  localparam int S = WIDTH / SEGMENTS;
  localparam int L = SEGMENTS - 1;

  logic [SEGMENTS-1:0] v_r;
  logic [SEGMENTS-1:0] c_r;
  logic [WIDTH-1:0]    sum_r [SEGMENTS];
  logic [WIDTH-1:0]    x_r   [SEGMENTS];
  logic [WIDTH-1:0]    y_r   [SEGMENTS];
  logic [1:0]          op_r  [SEGMENTS];
  logic                am_r  [SEGMENTS];
  logic                ovf_r;

  // Per-stage inputs: stage 0 from the prepared operands, others from the previous register.
  logic [SEGMENTS-1:0] in_v;
  logic [SEGMENTS-1:0] in_c;
  logic [SEGMENTS-1:0] in_am;
  logic [WIDTH-1:0]    in_s  [SEGMENTS];
  logic [WIDTH-1:0]    in_x  [SEGMENTS];
  logic [WIDTH-1:0]    in_y  [SEGMENTS];
  logic [1:0]          in_op [SEGMENTS];

  logic [WIDTH-1:0]    nxt_sum [SEGMENTS];
  logic [SEGMENTS-1:0] nxt_c;
  logic [S:0]          seg;

  logic [WIDTH-1:0] x0, y0;
  logic             c0;
  logic             stall;
  logic             ovf_raw;
  logic [WIDTH-1:0] q_sat;

  assign stall         = v_r[L] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v_r[L];
  assign bus.q         = sum_r[L];
  assign bus.cout      = c_r[L];
  assign bus.ovf       = ovf_r;

  always_comb begin
    x0 = bus.a;
    y0 = bus.b;
    c0 = bus.cin;
    case (bus.op)
      2'b01: begin
        y0 = ~bus.b;
        c0 = 1'b1;
      end
      2'b10:   y0 = '0;
      default: ;
    endcase
  end

  always_comb begin
    in_v     = '0;
    in_c     = '0;
    in_am    = '0;
    in_s     = '{default: '0};
    in_x     = '{default: '0};
    in_y     = '{default: '0};
    in_op    = '{default: '0};
    in_v[0]  = bus.in_valid;
    in_c[0]  = c0;
    in_am[0] = bus.a[WIDTH-1];
    in_x[0]  = x0;
    in_y[0]  = y0;
    in_op[0] = bus.op;
    for (int k = 1; k < SEGMENTS; k++) begin
      in_v[k]  = v_r[k-1];
      in_c[k]  = c_r[k-1];
      in_am[k] = am_r[k-1];
      in_s[k]  = sum_r[k-1];
      in_x[k]  = x_r[k-1];
      in_y[k]  = y_r[k-1];
      in_op[k] = op_r[k-1];
    end
  end

  always_comb begin
    seg     = '0;
    nxt_c   = '0;
    nxt_sum = '{default: '0};
    for (int k = 0; k < SEGMENTS; k++) begin
      seg = {1'b0, in_x[k][k*S +: S]} + {1'b0, in_y[k][k*S +: S]} + {{S{1'b0}}, in_c[k]};
      nxt_sum[k]           = in_s[k];
      nxt_sum[k][k*S +: S] = seg[S-1:0];
      nxt_c[k]             = seg[S];
    end
  end

  // Flags always describe the raw sum; only q is clamped.
  always_comb begin
    ovf_raw = (in_x[L][WIDTH-1] == in_y[L][WIDTH-1]) &&
              (nxt_sum[L][WIDTH-1] != in_x[L][WIDTH-1]);
    q_sat   = nxt_sum[L];
    if (SAT == 1) begin
      if (in_op[L] == 2'b01) begin
        if (!nxt_c[L]) q_sat = '0;
      end else if (nxt_c[L]) begin
        q_sat = '1;
      end
    end else if (SAT == 2 && ovf_raw) begin
      q_sat = in_am[L] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r   <= '0;
      c_r   <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < SEGMENTS; k++) begin
        sum_r[k] <= '0;
        x_r[k]   <= '0;
        y_r[k]   <= '0;
        op_r[k]  <= '0;
        am_r[k]  <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        v_r[k]   <= in_v[k];
        c_r[k]   <= nxt_c[k];
        sum_r[k] <= (k == L) ? q_sat : nxt_sum[k];
        x_r[k]   <= in_x[k];
        y_r[k]   <= in_y[k];
        op_r[k]  <= in_op[k];
        am_r[k]  <= in_am[k];
      end
      ovf_r <= ovf_raw;
    end
  end
endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: directed vectors on 16-bit instances (wrap,
// unsigned and signed clamp) plus a random 24-bit/3-segment run with mid-run reset.
module tb_pipe_addsub;
  typedef struct packed {
    logic [23:0] q;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   bp_en = 0;
  int   bp_cnt = 0;
  int   rmode = 0;
  exp_t sb0[$], sb1[$], sb2[$], sb3[$];
  exp_t e0, e1, e2, e3;
  int   out_cnt0 = 0, last_cyc0 = 0, prev_cyc0 = 0;
  logic prev_stall0 = 1'b0;
  logic [15:0] prev_q0 = '0;

  pipe_addsub_if #(.WIDTH(16)) if0 ();
  pipe_addsub_if #(.WIDTH(16)) if1 ();
  pipe_addsub_if #(.WIDTH(16)) if2 ();
  pipe_addsub_if #(.WIDTH(24)) if3 ();

  pipe_addsub #(.WIDTH(16), .SEGMENTS(4), .SAT(0)) dut0 (.clk(clk), .rst_n(rst0), .bus(if0.slave));
  pipe_addsub #(.WIDTH(16), .SEGMENTS(4), .SAT(1)) dut1 (.clk(clk), .rst_n(rst0), .bus(if1.slave));
  pipe_addsub #(.WIDTH(16), .SEGMENTS(4), .SAT(2)) dut2 (.clk(clk), .rst_n(rst0), .bus(if2.slave));
  pipe_addsub #(.WIDTH(24), .SEGMENTS(3), .SAT(0)) dut3 (.clk(clk), .rst_n(rst3), .bus(if3.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t model24(input logic [23:0] a, b, input logic cin, input logic [1:0] op);
    logic [23:0] x, y;
    logic        c;
    logic [24:0] s;
    x = a;
    y = b;
    c = cin;
    if (op == 2'b01) begin
      y = ~b;
      c = 1'b1;
    end else if (op == 2'b10) begin
      y = '0;
    end
    s = {1'b0, x} + {1'b0, y} + {24'b0, c};
    return exp_t'{q: s[23:0], c: s[24], o: (x[23] == y[23]) && (s[23] != x[23])};
  endfunction

  // out_ready drivers: DUT0 follows the 1,0,0 pattern under backpressure, DUT3 by mode.
  always @(posedge clk) begin
    #1;
    if0.out_ready = bp_en ? (bp_cnt % 3 == 0) : 1'b1;
    if (bp_en) bp_cnt++;
    case (rmode)
      0:       if3.out_ready = 1'b1;
      1:       if3.out_ready = 1'($urandom_range(0, 1));
      default: if3.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) if (mon_en) begin
    chk("in_ready0", {31'b0, if0.in_ready}, {31'b0, !(if0.out_valid && !if0.out_ready)});
    if (prev_stall0) chk("hold_q0", {16'b0, if0.q}, {16'b0, prev_q0});
    prev_stall0 = if0.out_valid && !if0.out_ready;
    prev_q0     = if0.q;
    if (if0.out_valid && if0.out_ready) begin
      out_cnt0++;
      prev_cyc0 = last_cyc0;
      last_cyc0 = cyc;
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra0: got q %0h expected no output", if0.q);
      end else begin
        e0 = sb0.pop_front();
        chk("q0", {16'b0, if0.q}, {8'b0, e0.q});
        chk("cout0", {31'b0, if0.cout}, {31'b0, e0.c});
        chk("ovf0", {31'b0, if0.ovf}, {31'b0, e0.o});
      end
    end
  end

  always @(negedge clk) if (mon_en && if1.out_valid && if1.out_ready) begin
    if (sb1.size() == 0) begin
      checks++; errors++;
      $display("FAIL extra1: got q %0h expected no output", if1.q);
    end else begin
      e1 = sb1.pop_front();
      chk("q1", {16'b0, if1.q}, {8'b0, e1.q});
      chk("cout1", {31'b0, if1.cout}, {31'b0, e1.c});
      chk("ovf1", {31'b0, if1.ovf}, {31'b0, e1.o});
    end
  end

  always @(negedge clk) if (mon_en && if2.out_valid && if2.out_ready) begin
    if (sb2.size() == 0) begin
      checks++; errors++;
      $display("FAIL extra2: got q %0h expected no output", if2.q);
    end else begin
      e2 = sb2.pop_front();
      chk("q2", {16'b0, if2.q}, {8'b0, e2.q});
      chk("cout2", {31'b0, if2.cout}, {31'b0, e2.c});
      chk("ovf2", {31'b0, if2.ovf}, {31'b0, e2.o});
    end
  end

  always @(negedge clk) if (mon_en && if3.out_valid && if3.out_ready) begin
    if (sb3.size() == 0) begin
      checks++; errors++;
      $display("FAIL extra3: got q %0h expected no output", if3.q);
    end else begin
      e3 = sb3.pop_front();
      chk("q3", {8'b0, if3.q}, {8'b0, e3.q});
      chk("cout3", {31'b0, if3.cout}, {31'b0, e3.c});
      chk("ovf3", {31'b0, if3.ovf}, {31'b0, e3.o});
    end
  end

  task automatic send0(input logic [15:0] a, b, input logic cin, input logic [1:0] op,
                       input logic [23:0] eq, input logic ec, input logic eo);
    bit acc = 0;
    int n = 0;
    sb0.push_back(exp_t'{q: eq, c: ec, o: eo});
    if0.a = a; if0.b = b; if0.cin = cin; if0.op = op; if0.in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = if0.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept0: got no in_ready expected accept within 100 cycles");
    end
    if0.in_valid = 1'b0;
  endtask

  task automatic send3(input logic [23:0] a, b, input logic cin, input logic [1:0] op, input bit push);
    bit acc = 0;
    int n = 0;
    if (push) sb3.push_back(model24(a, b, cin, op));
    if3.a = a; if3.b = b; if3.cin = cin; if3.op = op; if3.in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = if3.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept3: got no in_ready expected accept within 100 cycles");
    end
    if3.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb0.size() + sb1.size() + sb2.size() + sb3.size()) != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL drain: got %0d results pending expected 0", sb0.size() + sb1.size() + sb2.size() + sb3.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0;
    rst3 = 1'b0;
    if0.in_valid = 1'b1; if0.a = 16'h1111; if0.b = 16'h2222; if0.cin = 1'b0; if0.op = 2'b00;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.op = 2'b00; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.op = 2'b00; if2.out_ready = 1'b1;
    if3.in_valid = 1'b1; if3.a = 24'h123; if3.b = 24'h456; if3.cin = 1'b0; if3.op = 2'b00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid0", {31'b0, if0.out_valid}, 32'd0);
      chk("rst_valid3", {31'b0, if3.out_valid}, 32'd0);
    end
    if0.in_valid = 1'b0;
    if3.in_valid = 1'b0;
    rst0 = 1'b1;
    rst3 = 1'b1;
    mon_en = 1;
    @(negedge clk);
    chk("rst_q0", {16'b0, if0.q}, 32'd0);
    chk("rst_in_ready0", {31'b0, if0.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Cross-segment carry and its latency
    send0(16'h0FFF, 16'h0001, 1'b0, 2'b00, 24'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("latency0", {31'b0, if0.out_valid}, {31'b0, i == 3});
    end
    @(posedge clk);
    #1;
    send0(16'hFFFF, 16'h0001, 1'b1, 2'b00, 24'h0001, 1'b1, 1'b0);
    drain();

    send0(16'h0005, 16'h0007, 1'b0, 2'b01, 24'hFFFE, 1'b0, 1'b0);
    send0(16'h7FFF, 16'h0000, 1'b1, 2'b10, 24'h8000, 1'b0, 1'b1);
    drain();
    chk("consecutive0", last_cyc0 - prev_cyc0, 32'd1);
    send0(16'h1234, 16'h1111, 1'b1, 2'b11, 24'h2346, 1'b0, 1'b0);
    drain();

    begin : backpressure
      int base;
      base  = out_cnt0;
      bp_en = 1;
      for (int i = 0; i < 8; i++)
        send0(16'(i), 16'(i), 1'b0, 2'b00, 24'(2 * i), 1'b0, 1'b0);
      drain();
      chk("bp_count0", out_cnt0 - base, 32'd8);
      bp_en = 0;
    end

    // Saturating instances: unsigned clamp on dut1, signed clamp on dut2
    if1.in_valid = 1'b1; if1.a = 16'hFFF0; if1.b = 16'h0020; if1.cin = 1'b0; if1.op = 2'b00;
    if2.in_valid = 1'b1; if2.a = 16'h8000; if2.b = 16'h0001; if2.cin = 1'b0; if2.op = 2'b01;
    sb1.push_back(exp_t'{q: 24'hFFFF, c: 1'b1, o: 1'b0});
    sb2.push_back(exp_t'{q: 24'h8000, c: 1'b1, o: 1'b1});
    @(posedge clk);
    #1;
    if1.a = 16'h0001; if1.b = 16'h0002; if1.op = 2'b01;
    if2.a = 16'h7FFF; if2.b = 16'h0001; if2.op = 2'b00;
    sb1.push_back(exp_t'{q: 24'h0000, c: 1'b0, o: 1'b0});
    sb2.push_back(exp_t'{q: 24'h7FFF, c: 1'b0, o: 1'b1});
    @(posedge clk);
    #1;
    if1.a = 16'h0001; if1.b = 16'h0002; if1.op = 2'b00;
    if2.a = 16'hFFFF; if2.b = 16'hFFFF; if2.op = 2'b00;
    sb1.push_back(exp_t'{q: 24'h0003, c: 1'b0, o: 1'b0});
    sb2.push_back(exp_t'{q: 24'hFFFE, c: 1'b1, o: 1'b0});
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    drain();

    rmode = 1;
    for (int i = 0; i < 1000; i++) begin
      send3(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Three beats stuck in the pipe, then reset: none may surface
    rmode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send3(24'h000001, 24'h000002, 1'b0, 2'b00, 0);
    send3(24'h000003, 24'h000004, 1'b0, 2'b00, 0);
    send3(24'h000005, 24'h000006, 1'b0, 2'b00, 0);
    rst3 = 1'b0;
    @(posedge clk);
    #1;
    rst3  = 1'b1;
    rmode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid3", {31'b0, if3.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send3(24'hFFFFFF, 24'h000001, 1'b0, 2'b00, 1);
    send3(24'h800000, 24'h000001, 1'b0, 2'b01, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
